// File: rtl/nn_pkg.sv
// Shared definitions for the neural-layer datapath blocks: sequencer state
// encoding, default sizing and index-width helper.
package nn_pkg;

  localparam int DEF_NUM_INPUT  = 784;
  localparam int DEF_NUM_NEURON = 30;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    WAIT,
    DRAIN
  } seq_state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_in_buf.sv
// Input-vector storage for the layer sequencer: one write port, one
// registered read port.
module layer_in_buf
  import nn_pkg::*;
#(
  parameter int DEPTH = DEF_NUM_INPUT,
  parameter int WIDTH = DEF_DATA_WIDTH,
  localparam int AW   = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write-through bypass so a single-entry vector streams its fresh sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Collects one input vector, streams it to a neuron layer, gathers every
// neuron's result and serializes the results downstream.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_INPUT  = DEF_NUM_INPUT,
  parameter int NUM_NEURON = DEF_NUM_NEURON,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            neu_data,
  output logic                             neu_valid,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] neu_out,
  input  logic [NUM_NEURON-1:0]            neu_outvalid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             timeout_err
);

  localparam int IW = idx_w(NUM_INPUT);
  localparam int NW = idx_w(NUM_NEURON);
  localparam int CW = idx_w(TIMEOUT);
  localparam logic [IW-1:0] LAST_IN  = IW'(NUM_INPUT - 1);
  localparam logic [NW-1:0] LAST_NEU = NW'(NUM_NEURON - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  seq_state_t state, state_nx;
  logic [IW-1:0] wr_idx, wr_idx_nx, st_idx, st_idx_nx, rd_addr;
  logic [NW-1:0] rd_idx, rd_idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_NEURON-1:0] flag, flag_nx;
  logic timeout_nx, in_fire, out_fire;
  logic [DATA_WIDTH-1:0] res [NUM_NEURON];

  assign in_ready  = (state == IDLE) || (state == FILL);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? res[rd_idx] : '0;

  layer_in_buf #(
    .DEPTH(NUM_INPUT),
    .WIDTH(DATA_WIDTH)
  ) u_in_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (in_fire),
    .wr_addr(wr_idx),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(neu_data)
  );

  always_comb begin
    state_nx   = state;
    wr_idx_nx  = wr_idx;
    st_idx_nx  = st_idx;
    rd_idx_nx  = rd_idx;
    cnt_nx     = cnt;
    flag_nx    = flag;
    timeout_nx = 1'b0;
    rd_addr    = '0;
    case (state)
      IDLE, FILL: begin
        if (in_fire) begin
          if (wr_idx == LAST_IN) begin
            wr_idx_nx = '0;
            st_idx_nx = '0;
            state_nx  = STREAM;
          end else begin
            wr_idx_nx = wr_idx + 1'b1;
            state_nx  = FILL;
          end
        end
      end
      // Read address runs one ahead so the registered read lines up with neu_valid.
      STREAM: begin
        if (st_idx == LAST_IN) begin
          state_nx = WAIT;
          cnt_nx   = '0;
          flag_nx  = '0;
        end else begin
          st_idx_nx = st_idx + 1'b1;
          rd_addr   = st_idx + 1'b1;
        end
      end
      WAIT: begin
        flag_nx = flag | neu_outvalid;
        if (&flag_nx) begin
          state_nx  = DRAIN;
          rd_idx_nx = '0;
        end else if (cnt == LAST_CNT) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (rd_idx == LAST_NEU) state_nx = IDLE;
          else                    rd_idx_nx = rd_idx + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_idx      <= '0;
      st_idx      <= '0;
      rd_idx      <= '0;
      cnt         <= '0;
      flag        <= '0;
      neu_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_idx      <= wr_idx_nx;
      st_idx      <= st_idx_nx;
      rd_idx      <= rd_idx_nx;
      cnt         <= cnt_nx;
      flag        <= flag_nx;
      neu_valid   <= (state_nx == STREAM);
      timeout_err <= timeout_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (state == WAIT) begin
      for (int k = 0; k < NUM_NEURON; k++) begin
        if (neu_outvalid[k]) res[k] <= neu_out[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized scoreboard bench for layer_sequencer: stimulus queues expected
// stream samples and drained results, a negedge monitor checks them.
module tb_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int PLAN_LEN = 12;

  logic clk, rst_n;
  logic [DW-1:0] in_data, neu_data, out_data;
  logic in_valid, in_ready, neu_valid, out_valid, out_ready, timeout_err;
  logic [NN*DW-1:0] neu_out;
  logic [NN-1:0] neu_outvalid;

  int total, bad, exp_to, obs_to, ready_mode;
  logic [DW-1:0] exp_neu [$];
  logic [DW-1:0] exp_out [$];
  logic [DW-1:0] vec [NI];
  logic [NN-1:0] plan_mask [1:PLAN_LEN];
  logic [DW-1:0] plan_val [1:PLAN_LEN][NN];

  layer_sequencer #(
    .NUM_INPUT(NI), .NUM_NEURON(NN), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .neu_data(neu_data), .neu_valid(neu_valid),
    .neu_out(neu_out), .neu_outvalid(neu_outvalid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %0h, expected nothing pending (t=%0t)", name, act, $time);
  endtask

  // Downstream ready: random, hold-low for the first five DRAIN cycles, or always ready.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!out_valid) hold_cnt = 0;
      case (ready_mode)
        1: begin
          if (out_valid && hold_cnt < 5) begin
            out_ready = 1'b0;
            hold_cnt++;
          end else out_ready = 1'b1;
        end
        2: out_ready = 1'b1;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  initial begin : monitor
    int run, since;
    bit track, prev_hold;
    logic [DW-1:0] prev_data, e;
    run = 0; since = 0; track = 0; prev_hold = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; track = 0; prev_hold = 0;
        continue;
      end
      if (neu_valid) begin
        run++;
        checkOutput("in_ready_stream", 32'(in_ready), 32'd0);
        if (exp_neu.size() == 0) failNote("neu_unexpected", 32'(neu_data));
        else begin
          e = exp_neu.pop_front();
          checkOutput("neu_data", 32'(neu_data), 32'(e));
        end
      end else if (run > 0) begin
        checkOutput("stream_len", run, NI);
        run = 0; track = 1; since = 0;
      end else if (track) begin
        since++;
      end
      if (timeout_err) begin
        obs_to++;
        checkOutput("timeout_delay", since, TO);
        checkOutput("timeout_in_ready", 32'(in_ready), 32'd1);
        track = 0;
      end
      if (out_valid) begin
        track = 0;
        checkOutput("in_ready_drain", 32'(in_ready), 32'd0);
        if (prev_hold) checkOutput("out_hold", 32'(out_data), 32'(prev_data));
        if (exp_out.size() == 0) failNote("out_unexpected", 32'(out_data));
        else if (out_ready) begin
          e = exp_out.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic clearPlan();
    for (int i = 1; i <= PLAN_LEN; i++) begin
      plan_mask[i] = '0;
      for (int k = 0; k < NN; k++) plan_val[i][k] = 16'($urandom);
    end
  endtask

  task automatic randomPlan();
    for (int i = 1; i <= PLAN_LEN; i++) begin
      for (int k = 0; k < NN; k++) begin
        plan_mask[i][k] = ($urandom_range(3) == 0);
        plan_val[i][k] = 16'($urandom);
      end
    end
  endtask

  // Load vec into the block, junk neuron pulses meanwhile; ends at posedge+1 after last transfer.
  task automatic applyStimulus(input int max_gap);
    for (int j = 0; j < NI; j++) begin
      repeat ($urandom_range(max_gap)) begin
        in_valid = 1'b0;
        neu_outvalid = NN'($urandom);
        neu_out = (NN*DW)'({$urandom, $urandom});
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = vec[j];
      exp_neu.push_back(vec[j]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    neu_outvalid = '0;
    checkOutput("in_ready_after_fill", 32'(in_ready), 32'd0);
  endtask

  task automatic waitStream(output bit ok);
    bit seen;
    seen = 0;
    ok = 0;
    for (int c = 0; c < 4*NI + 8; c++) begin
      @(negedge clk);
      if (neu_valid) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    if (!ok) failNote("stream_wait_expired", 32'(seen));
  endtask

  // Reference: results are each neuron's latest pulse; completion must fall within the WAIT window.
  task automatic neuronPhase();
    logic [DW-1:0] res [NN];
    logic [NN-1:0] got;
    int done_i;
    bit tmo;
    got = '0; done_i = 0; tmo = 0;
    for (int i = 1; i <= PLAN_LEN && done_i == 0 && !tmo; i++) begin
      for (int k = 0; k < NN; k++) begin
        if (plan_mask[i][k]) begin
          res[k] = plan_val[i][k];
          got[k] = 1'b1;
        end
      end
      if (&got) done_i = i;
      else if (i >= TO - 1) tmo = 1;
    end
    if (tmo) exp_to++;
    for (int i = 1; i <= PLAN_LEN; i++) begin
      @(posedge clk);
      #1;
      if (i == done_i) for (int k = 0; k < NN; k++) exp_out.push_back(res[k]);
      neu_outvalid = plan_mask[i];
      for (int k = 0; k < NN; k++) neu_out[k*DW +: DW] = plan_val[i][k];
      in_valid = !in_ready && ($urandom_range(1) == 1);
      in_data = 16'($urandom);
    end
    @(posedge clk);
    #1;
    neu_outvalid = '0;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      if (in_ready && !out_valid && exp_out.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
      in_valid = !in_ready && ($urandom_range(1) == 1);
      in_data = 16'($urandom);
    end
    in_valid = 1'b0;
    if (!ok) failNote("idle_wait_expired", 32'(exp_out.size()));
  endtask

  task automatic runLayer(input int max_gap);
    bit ok;
    applyStimulus(max_gap);
    waitStream(ok);
    if (ok) neuronPhase();
    waitIdle();
  endtask

  initial begin
    total = 0; bad = 0; exp_to = 0; obs_to = 0; ready_mode = 2;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; neu_outvalid = '0; neu_out = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_neu_valid", 32'(neu_valid), 32'd0);
    checkOutput("rst_neu_data", 32'(neu_data), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] contiguous 1,2,3,4 with simultaneous results");
    for (int j = 0; j < NI; j++) vec[j] = 16'(j + 1);
    clearPlan();
    plan_mask[1] = 2'b11; plan_val[1][0] = 16'h0010; plan_val[1][1] = 16'h0020;
    runLayer(0);

    $display("[TB] neuron 1 then neuron 0 three cycles apart");
    for (int j = 0; j < NI; j++) vec[j] = 16'($urandom);
    clearPlan();
    plan_mask[1] = 2'b10; plan_val[1][1] = 16'hBEEF;
    plan_mask[4] = 2'b01; plan_val[4][0] = 16'h1234;
    runLayer(2);

    $display("[TB] downstream stall in DRAIN");
    ready_mode = 1;
    clearPlan();
    plan_mask[2] = 2'b11; plan_val[2][0] = 16'hA5A5; plan_val[2][1] = 16'h5A5A;
    runLayer(1);
    ready_mode = 2;

    $display("[TB] only neuron 0 responds");
    clearPlan();
    plan_mask[1] = 2'b01;
    runLayer(0);
    checkOutput("after_timeout_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] reset during third STREAM cycle");
    for (int j = 0; j < NI; j++) vec[j] = 16'($urandom);
    applyStimulus(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_neu_valid", 32'(neu_valid), 32'd0);
    checkOutput("midrst_neu_data", 32'(neu_data), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_neu.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < NI; j++) vec[j] = 16'(16'h0100 + j);
    clearPlan();
    plan_mask[3] = 2'b11;
    runLayer(1);

    $display("[TB] randomized layers");
    ready_mode = 0;
    for (int n = 0; n < 25; n++) begin
      for (int j = 0; j < NI; j++) vec[j] = 16'($urandom);
      randomPlan();
      runLayer(3);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("timeout_count", obs_to, exp_to);
    checkOutput("neu_queue_empty", exp_neu.size(), 0);
    checkOutput("out_queue_empty", exp_out.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
